// File: rtl/chunk_comparator_pkg.sv
// chunk_comparator_pkg: FSM state and result types shared by the chunk comparator
package chunk_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } result_t;

endpackage

// File: rtl/chunk_comparator_chunk_cmp.sv
// chunk_cmp: combinational unsigned magnitude compare of one chunk
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // plain three-way compare; signedness is handled by the caller flipping MSBs
    always_comb begin
        eq = (x == y);
        lt = (x < y);
        gt = (x > y);
    end

endmodule

// File: rtl/chunk_comparator.sv
// chunk_comparator: multi-cycle MSB-first chunked comparator with early exit
// Optional feature macro: CHUNK_CMP_SIGNED_EN adds signed_mode (two's complement compare)
module chunk_comparator
    import chunk_comparator_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef CHUNK_CMP_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         busy,
    output logic         done,
    output logic         equal,
    output logic         less_than,
    output logic         greater_than
);

    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    if (N % CHUNK != 0) begin : g_bad_chunk
        $error("chunk_comparator: N must be an integer multiple of CHUNK");
    end

    state_t               state, state_nx;
    logic [N-1:0]         a_r, b_r;
    logic [IW-1:0]        idx;
    result_t              res;
    logic [CHUNK-1:0]     x, y, fm;
    logic                 c_eq, c_lt, c_gt;
    logic                 last;

    assign last = (idx == '0);

`ifdef CHUNK_CMP_SIGNED_EN
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);
    logic sgn_r;
    // inverting both sign bits on the top chunk turns a signed compare into an unsigned one
    assign fm = (sgn_r && idx == IW'(K - 1)) ? MSB_MASK : '0;
`else
    assign fm = '0;
`endif

    // select the indexed chunk of each latched operand
    always_comb begin
        x = a_r[int'(idx) * CHUNK +: CHUNK] ^ fm;
        y = b_r[int'(idx) * CHUNK +: CHUNK] ^ fm;
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .x  (x),
        .y  (y),
        .eq (c_eq),
        .lt (c_lt),
        .gt (c_gt)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: accept in IDLE, exit RUN on first difference or last chunk
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (!c_eq || last) ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: latch operands on accept, walk the index, register the verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            idx <= '0;
            res <= '0;
`ifdef CHUNK_CMP_SIGNED_EN
            sgn_r <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a_r <= a;
            b_r <= b;
            idx <= IW'(K - 1);
`ifdef CHUNK_CMP_SIGNED_EN
            sgn_r <= signed_mode;
`endif
        end else if (state == RUN) begin
            if (!c_eq)     res <= '{eq: 1'b0, lt: c_lt, gt: c_gt};
            else if (last) res <= '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
            else           idx <= idx - 1'b1;
        end
    end

    // outputs decoded from state and the held result
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == DONE);
        equal        = res.eq;
        less_than    = res.lt;
        greater_than = res.gt;
    end

endmodule
